// File: rtl/beep_pattern_gen_if.sv
// Request/status bundle between the key/event logic and the buzzer pattern generator.
// The master issues beep requests and aborts; the slave reports busy/done and drives the pin.
interface beep_pattern_gen_if;
    logic       req;
    logic [3:0] req_cnt;
    logic       abort;
    logic       busy;
    logic       done;
    logic       beep;

    modport master (
        output req,
        output req_cnt,
        output abort,
        input  busy,
        input  done,
        input  beep
    );

    modport slave (
        input  req,
        input  req_cnt,
        input  abort,
        output busy,
        output done,
        output beep
    );
endinterface

// File: rtl/beep_pattern_gen.sv
// Buzzer burst generator: plays req_cnt bursts of a square-wave tone, each burst an ON window
// followed by an OFF gap (no gap after the last burst), reporting busy and a done pulse.
module beep_pattern_gen #(
    parameter int   TONE_HALF   = 25000,
    parameter int   ON_CYC      = 10000000,
    parameter int   OFF_CYC     = 5000000,
    parameter logic BEEP_ON_LVL = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    beep_pattern_gen_if.slave   bus
);

    localparam int PH_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int TN_W   = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_CYC - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_CYC - 1);
    localparam logic [TN_W-1:0] TN_LAST  = TN_W'(TONE_HALF - 1);
    localparam logic            IDLE_LVL = ~BEEP_ON_LVL;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    state_t          r_state,     w_state;
    logic [3:0]      r_remaining, w_remaining;
    logic [PH_W-1:0] r_phase,     w_phase;
    logic [TN_W-1:0] r_toneCnt,   w_toneCnt;
    logic            r_tone,      w_tone;
    logic            r_busy,      w_busy;
    logic            r_done,      w_done;
    logic            r_beep,      w_beep;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_phase     <= '0;
            r_toneCnt   <= '0;
            r_tone      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_beep      <= IDLE_LVL;
        end else begin
            r_state     <= w_state;
            r_remaining <= w_remaining;
            r_phase     <= w_phase;
            r_toneCnt   <= w_toneCnt;
            r_tone      <= w_tone;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_beep      <= w_beep;
        end
    end

    // Abort outranks completion; requests only matter in IDLE, so a req while busy is simply dropped.
    always_comb begin
        w_state     = r_state;
        w_remaining = r_remaining;
        w_phase     = r_phase;
        w_toneCnt   = r_toneCnt;
        w_tone      = r_tone;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_beep      = r_beep;

        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                w_beep = IDLE_LVL;
                if (bus.req && (bus.req_cnt != 4'd0)) begin
                    w_state     = ON;
                    w_busy      = 1'b1;
                    w_remaining = bus.req_cnt;
                    w_phase     = '0;
                    w_toneCnt   = '0;
                    w_tone      = 1'b1;
                    w_beep      = BEEP_ON_LVL;
                end
            end

            ON: begin
                if (bus.abort) begin
                    w_state = IDLE;
                    w_busy  = 1'b0;
                    w_phase = '0;
                    w_beep  = IDLE_LVL;
                end else if (r_phase == ON_LAST) begin
                    w_remaining = r_remaining - 4'd1;
                    w_phase     = '0;
                    w_beep      = IDLE_LVL;
                    if (r_remaining == 4'd1) begin
                        w_state = IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_state = OFF;
                    end
                end else begin
                    w_phase = r_phase + PH_W'(1);
                    if (r_toneCnt == TN_LAST) begin
                        w_toneCnt = '0;
                        w_tone    = ~r_tone;
                    end else begin
                        w_toneCnt = r_toneCnt + TN_W'(1);
                    end
                    w_beep = w_tone ? BEEP_ON_LVL : IDLE_LVL;
                end
            end

            OFF: begin
                if (bus.abort) begin
                    w_state = IDLE;
                    w_busy  = 1'b0;
                    w_phase = '0;
                    w_beep  = IDLE_LVL;
                end else if (r_phase == OFF_LAST) begin
                    w_state   = ON;
                    w_phase   = '0;
                    w_toneCnt = '0;
                    w_tone    = 1'b1;
                    w_beep    = BEEP_ON_LVL;
                end else begin
                    w_phase = r_phase + PH_W'(1);
                    w_beep  = IDLE_LVL;
                end
            end

            default: begin
                w_state = IDLE;
                w_busy  = 1'b0;
                w_beep  = IDLE_LVL;
            end
        endcase
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.beep = r_beep;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Scoreboard bench for beep_pattern_gen: each directed step pushes the expected per-cycle
// {busy,done,beep} trace, which is popped and compared one cycle at a time.
module tb_beep_pattern_gen;

    localparam int   TONE_HALF   = 2;
    localparam int   ON_CYC      = 10;
    localparam int   OFF_CYC     = 6;
    localparam logic BEEP_ON_LVL = 1'b1;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    beep_pattern_gen_if bif();

    beep_pattern_gen #(
        .TONE_HALF   (TONE_HALF),
        .ON_CYC      (ON_CYC),
        .OFF_CYC     (OFF_CYC),
        .BEEP_ON_LVL (BEEP_ON_LVL)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bif.slave)
    );

    always #10 sys_clk = ~sys_clk;

    logic [2:0] expQ[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pushIdle(input int n);
        for (int i = 0; i < n; i++) expQ.push_back(3'b000);
    endtask

    // Expected trace for an n-burst request; truncAt >= 0 cuts it off where abort/reset lands.
    task automatic pushModel(input int n, input int truncAt);
        int c;
        logic tone;
        c = 0;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < ON_CYC; i++) begin
                tone = ((i / TONE_HALF) % 2) == 0;
                if (truncAt < 0 || c <= truncAt)
                    expQ.push_back({1'b1, 1'b0, tone ? BEEP_ON_LVL : ~BEEP_ON_LVL});
                c++;
            end
            if (b < n - 1) begin
                for (int i = 0; i < OFF_CYC; i++) begin
                    if (truncAt < 0 || c <= truncAt)
                        expQ.push_back({1'b1, 1'b0, ~BEEP_ON_LVL});
                    c++;
                end
            end
        end
        if (truncAt < 0) expQ.push_back({1'b0, 1'b1, ~BEEP_ON_LVL});
        pushIdle(3);
    endtask

    task automatic checkOutput(input string tag);
        logic [2:0] obs;
        logic [2:0] exp;
        obs = {bif.busy, bif.done, bif.beep};
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL %s: scoreboard empty, busy/done/beep obs=%b", tag, obs);
        end else begin
            exp = expQ.pop_front();
            assert (obs === exp) else begin
                mismatched++;
                $error("[TB] FAIL %s: busy/done/beep obs=%b exp=%b", tag, obs, exp);
            end
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // One request plus optional mid-run events, indexed by cycle after the accept edge (-1 = none).
    task automatic applyStimulus(input string tag, input int cnt, input int injectAt,
                                 input int injectCnt, input int abortAt, input int rstAt);
        int c;
        int truncAt;
        int busyCnt;
        int doneCnt;
        int expBusy;
        int expDone;
        truncAt = (abortAt >= 0) ? abortAt : rstAt;
        if (cnt == 0) begin
            pushIdle(4);
            expBusy = 0;
            expDone = 0;
        end else begin
            pushModel(cnt, truncAt);
            expBusy = (truncAt >= 0) ? truncAt + 1 : cnt * ON_CYC + (cnt - 1) * OFF_CYC;
            expDone = (truncAt >= 0) ? 0 : 1;
        end
        busyCnt = 0;
        doneCnt = 0;
        c = 0;
        bif.req     = 1'b1;
        bif.req_cnt = 4'(cnt);
        while (expQ.size() > 0 && c < 500) begin
            tick();
            busyCnt += int'(bif.busy);
            doneCnt += int'(bif.done);
            checkOutput(tag);
            bif.req     = (c == injectAt);
            bif.req_cnt = (c == injectAt) ? 4'(injectCnt) : 4'(cnt);
            bif.abort   = (c == abortAt);
            sys_rst_n   = !(c == rstAt);
            c++;
        end
        bif.req   = 1'b0;
        bif.abort = 1'b0;
        sys_rst_n = 1'b1;
        checkCount({tag, " busy cycles"}, busyCnt, expBusy);
        checkCount({tag, " done pulses"}, doneCnt, expDone);
    endtask

    initial begin
        bif.req     = 1'b1;
        bif.req_cnt = 4'd3;
        bif.abort   = 1'b0;
        sys_rst_n   = 1'b0;

        $display("[TB] reset held with req asserted");
        pushIdle(2);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("reset");
        end
        sys_rst_n = 1'b1;
        bif.req   = 1'b0;
        pushIdle(3);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post-reset idle");
        end

        $display("[TB] single burst");
        applyStimulus("single", 1, -1, 0, -1, -1);

        $display("[TB] three bursts");
        applyStimulus("triple", 3, -1, 0, -1, -1);

        $display("[TB] zero count, then request while busy");
        applyStimulus("zero cnt", 0, -1, 0, -1, -1);
        applyStimulus("req while busy", 2, 5, 5, -1, -1);

        $display("[TB] abort in first OFF gap, then fresh request");
        applyStimulus("abort", 4, -1, 0, 14, -1);
        applyStimulus("after abort", 1, -1, 0, -1, -1);

        $display("[TB] reset during second ON window");
        applyStimulus("mid reset", 2, -1, 0, -1, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
